// File: rtl/multiples_pkg.sv
// Shared definitions for the 5-bit multiples generator.
// Contents: divisor-select codes, FSM state encoding, and the data width.
package multiples_pkg;

    localparam int NUM_W = 5;

    localparam logic [2:0] SEL_MUL2   = 3'd0;
    localparam logic [2:0] SEL_MUL3   = 3'd1;
    localparam logic [2:0] SEL_MUL4   = 3'd2;
    localparam logic [2:0] SEL_MUL5   = 3'd3;
    localparam logic [2:0] SEL_MUL235 = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiples_step_lut.sv
// Divisor-select to step decoder.
// Ports:
//   sel   in  3  divisor select code
//   step  out 5  increment between consecutive multiples (0 when illegal)
//   legal out 1  sel maps to a supported divisor
module multiples_step_lut
    import multiples_pkg::*;
(
    input  logic [2:0]       sel,
    output logic [NUM_W-1:0] step,
    output logic             legal
);

    always_comb begin
        step  = '0;
        legal = 1'b0;
        case (sel)
            SEL_MUL2:   begin step = 5'd2;  legal = 1'b1; end
            SEL_MUL3:   begin step = 5'd3;  legal = 1'b1; end
            SEL_MUL4:   begin step = 5'd4;  legal = 1'b1; end
            SEL_MUL5:   begin step = 5'd5;  legal = 1'b1; end
            SEL_MUL235: begin step = 5'd30; legal = 1'b1; end
            default:    begin step = '0;    legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multiples_gen_5bit.sv
// Emits every multiple of the selected divisor in 0..31, ascending, one per
// valid/ready transfer, then parks in DONE.
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  synchronous active-high reset
//   sel   in  3  divisor select (0:2 1:3 2:4 3:5 4:30, 5..7 illegal)
//   start in  1  begin a sequence (honoured in IDLE/DONE only)
//   ready in  1  consumer accepts num
//   num   out 5  current multiple
//   valid out 1  num is valid
//   idx   out 5  index of num within the sequence
//   done  out 1  sequence finished
//   err   out 1  last start used an illegal sel
module multiples_gen_5bit
    import multiples_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       sel,
    input  logic             start,
    input  logic             ready,
    output logic [NUM_W-1:0] num,
    output logic             valid,
    output logic [NUM_W-1:0] idx,
    output logic             done,
    output logic             err
);

    state_t           state, state_nxt;
    logic [2:0]       sel_q;
    logic [2:0]       lut_sel;
    logic [NUM_W-1:0] step;
    logic             legal;
    logic [NUM_W:0]   nxt;

    // While running, the step comes from the latched select so live sel
    // changes are ignored; otherwise decode the live sel to judge a start.
    assign lut_sel = (state == RUN) ? sel_q : sel;

    multiples_step_lut u_lut (
        .sel   (lut_sel),
        .step  (step),
        .legal (legal)
    );

    // Carry out of the 6-bit sum is the only end-of-sequence test.
    assign nxt = {1'b0, num} + {1'b0, step};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = legal ? RUN : DONE;
            RUN:        if (ready && nxt[NUM_W]) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
            num   <= '0;
            idx   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sel_q <= sel;
                        num   <= '0;
                        idx   <= '0;
                        err   <= ~legal;
                    end
                end
                RUN: begin
                    // On the final transfer num/idx keep the last value.
                    if (ready && !nxt[NUM_W]) begin
                        num <= nxt[NUM_W-1:0];
                        idx <= idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_multiples_gen_5bit.sv
module tb_multiples_gen_5bit;

    logic       clk;
    logic       rst;
    logic [2:0] sel;
    logic       start;
    logic       ready;
    logic [4:0] num;
    logic       valid;
    logic [4:0] idx;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    multiples_gen_5bit dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .start (start),
        .ready (ready),
        .num   (num),
        .valid (valid),
        .idx   (idx),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are changed and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0; sel = 3'd0;
        tick();
        rst = 1'b0;
        checks++;
        if ({num, idx, valid, done, err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs num=%0d idx=%0d valid=%b done=%b err=%b exp all 0",
                     num, idx, valid, done, err);
        end
    endtask

    task automatic test_mul5();
        sel = 3'd3; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (valid !== 1'b1 || num !== 5'(5 * i) || idx !== 5'(i) || done !== 1'b0) begin
                errors++;
                $display("FAIL mul5_seq i=%0d got v=%b num=%0d idx=%0d done=%b exp v=1 num=%0d idx=%0d done=0",
                         i, valid, num, idx, done, 5 * i, i);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || num !== 5'd30 || idx !== 5'd6 || err !== 1'b0) begin
            errors++;
            $display("FAIL mul5_done got done=%b v=%b num=%0d idx=%0d err=%b exp done=1 v=0 num=30 idx=6 err=0",
                     done, valid, num, idx, err);
        end
    endtask

    task automatic test_ready_toggle();
        sel = 3'd2; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ready = 1'b0;
            checks++;
            if (valid !== 1'b1 || num !== 5'(4 * i) || idx !== 5'(i)) begin
                errors++;
                $display("FAIL mul4_pre i=%0d got v=%b num=%0d idx=%0d exp v=1 num=%0d idx=%0d",
                         i, valid, num, idx, 4 * i, i);
            end
            tick();
            checks++;
            if (valid !== 1'b1 || num !== 5'(4 * i) || idx !== 5'(i)) begin
                errors++;
                $display("FAIL mul4_hold i=%0d got v=%b num=%0d idx=%0d exp v=1 num=%0d idx=%0d",
                         i, valid, num, idx, 4 * i, i);
            end
            ready = 1'b1;
            tick();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || num !== 5'd28) begin
            errors++;
            $display("FAIL mul4_done got done=%b v=%b num=%0d exp done=1 v=0 num=28",
                     done, valid, num);
        end
    endtask

    task automatic test_mul235_restart();
        sel = 3'd4; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (valid !== 1'b1 || num !== 5'd0 || idx !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mul235_first got v=%b num=%0d idx=%0d done=%b exp v=1 num=0 idx=0 done=0",
                     valid, num, idx, done);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || num !== 5'd30 || idx !== 5'd1) begin
            errors++;
            $display("FAIL mul235_second got v=%b num=%0d idx=%0d exp v=1 num=30 idx=1",
                     valid, num, idx);
        end
        tick();
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || num !== 5'd30) begin
            errors++;
            $display("FAIL mul235_done got done=%b v=%b num=%0d exp done=1 v=0 num=30",
                     done, valid, num);
        end
        // Restart from DONE with multiples of 2.
        sel = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (valid !== 1'b1 || done !== 1'b0 || num !== 5'(2 * i) || idx !== 5'(i)) begin
                errors++;
                $display("FAIL mul2_seq i=%0d got v=%b done=%b num=%0d idx=%0d exp v=1 done=0 num=%0d idx=%0d",
                         i, valid, done, num, idx, 2 * i, i);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || num !== 5'd30 || idx !== 5'd15) begin
            errors++;
            $display("FAIL mul2_done got done=%b v=%b num=%0d idx=%0d exp done=1 v=0 num=30 idx=15",
                     done, valid, num, idx);
        end
    endtask

    task automatic test_illegal();
        sel = 3'd6; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done !== 1'b1 || err !== 1'b1 || valid !== 1'b0) begin
                errors++;
                $display("FAIL illegal_hold c=%0d got done=%b err=%b v=%b exp done=1 err=1 v=0",
                         i, done, err, valid);
            end
            tick();
        end
        sel = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (valid !== 1'b1 || err !== 1'b0 || done !== 1'b0 || num !== 5'(3 * i) || idx !== 5'(i)) begin
                errors++;
                $display("FAIL illegal_recover i=%0d got v=%b err=%b done=%b num=%0d idx=%0d exp v=1 err=0 done=0 num=%0d idx=%0d",
                         i, valid, err, done, num, idx, 3 * i, i);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || num !== 5'd30 || idx !== 5'd10) begin
            errors++;
            $display("FAIL mul3_done got done=%b num=%0d idx=%0d exp done=1 num=30 idx=10",
                     done, num, idx);
        end
    endtask

    task automatic test_sel_change();
        sel = 3'd1; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            // Disturb sel and pulse start while the sequence is running.
            if (i == 2) begin sel = 3'd4; start = 1'b1; end
            if (i == 3) start = 1'b0;
            if (i == 5) sel = 3'd0;
            checks++;
            if (valid !== 1'b1 || num !== 5'(3 * i) || idx !== 5'(i)) begin
                errors++;
                $display("FAIL selchg_seq i=%0d got v=%b num=%0d idx=%0d exp v=1 num=%0d idx=%0d",
                         i, valid, num, idx, 3 * i, i);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || num !== 5'd30) begin
            errors++;
            $display("FAIL selchg_done got done=%b v=%b num=%0d exp done=1 v=0 num=30",
                     done, valid, num);
        end
    endtask

    task automatic test_reset_mid();
        sel = 3'd3; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (num !== 5'd15 || valid !== 1'b1 || idx !== 5'd3) begin
            errors++;
            $display("FAIL rstmid_pre got num=%0d v=%b idx=%0d exp num=15 v=1 idx=3",
                     num, valid, idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({num, idx, valid, done, err} !== 13'd0) begin
            errors++;
            $display("FAIL rstmid_after num=%0d idx=%0d v=%b done=%b err=%b exp all 0",
                     num, idx, valid, done, err);
        end
        tick();
        checks++;
        if ({num, idx, valid, done, err} !== 13'd0) begin
            errors++;
            $display("FAIL rstmid_idle num=%0d idx=%0d v=%b done=%b err=%b exp all 0",
                     num, idx, valid, done, err);
        end
        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        checks++;
        if ({num, idx, valid, done, err} !== 13'd0) begin
            errors++;
            $display("FAIL rst_priority num=%0d idx=%0d v=%b done=%b err=%b exp all 0",
                     num, idx, valid, done, err);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (valid !== 1'b1 || num !== 5'd0 || idx !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_restart got v=%b num=%0d idx=%0d exp v=1 num=0 idx=0",
                     valid, num, idx);
        end
        tick();
        checks++;
        if (num !== 5'd5 || idx !== 5'd1) begin
            errors++;
            $display("FAIL rstmid_restart2 got num=%0d idx=%0d exp num=5 idx=1", num, idx);
        end
    endtask

    initial begin
        rst = 1'b1; sel = 3'd0; start = 1'b0; ready = 1'b0;
        #2;
        test_reset();
        test_mul5();
        test_ready_toggle();
        test_mul235_restart();
        test_illegal();
        test_sel_change();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
